// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported 32-bit memory between instruction fetch (I) and the
// data memory controller (D). The winning request is registered onto the
// memory port; the memory's Ready/ReadData are routed back to the owner.
// Data traffic is preferred, but fetch is forced through after a bounded run
// of data grants. A hung access is aborted with a one-cycle bus-error pulse.

module mem_port_arbiter #(
  parameter int MAX_DATA_CONSEC = 4,   // D grants allowed back to back while I waits (>=1)
  parameter int TIMEOUT_CYCLES  = 255  // BUSY cycles without M_Ready before abort; 0 disables
) (
  input  logic        clock,
  input  logic        reset,

  // Instruction fetch requester
  input  logic [31:0] I_Address,
  input  logic        I_ReadEnable,
  output logic [31:0] I_ReadData,
  output logic        I_Ready,

  // Data controller requester
  input  logic [31:0] D_Address,
  input  logic [31:0] D_WriteData,
  input  logic [3:0]  D_WriteEnable,
  input  logic        D_ReadEnable,
  output logic [31:0] D_ReadData,
  output logic        D_Ready,

  // Memory port
  output logic [31:0] M_Address,
  output logic [31:0] M_WriteData,
  output logic [3:0]  M_WriteEnable,
  output logic        M_ReadEnable,
  input  logic [31:0] M_ReadData,
  input  logic        M_Ready,

  // Status
  output logic        Bus_Error,
  output logic        Grant_D
);

  // Port ownership states
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  // Counter widths: consec_d must reach MAX_DATA_CONSEC, the timeout counter
  // only ever needs to reach TIMEOUT_CYCLES-1.
  localparam int CW = $clog2(MAX_DATA_CONSEC + 1);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_DATA_CONSEC);
  localparam logic [TW-1:0] TMO_LAST   =
    TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic          TMO_EN     = (TIMEOUT_CYCLES > 0);

  logic [1:0]    state;
  logic [CW-1:0] consec_d;
  logic [TW-1:0] tmo_cnt;

  logic i_pend;
  logic d_pend;
  logic busy;
  logic grant_i;
  logic grant_d;
  logic timeout_hit;
  logic complete;

  // A requester is pending while it holds any enable; writes count as D requests.
  assign i_pend = I_ReadEnable;
  assign d_pend = D_ReadEnable | (|D_WriteEnable);

  assign busy = (state == BUSY_I) || (state == BUSY_D);

  // Abort on the last allowed BUSY cycle; a real M_Ready that same cycle wins.
  assign timeout_hit = TMO_EN && busy && !M_Ready && (tmo_cnt == TMO_LAST);
  assign complete    = busy && (M_Ready || timeout_hit);

  // Arbitration, evaluated only while the port is free.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (d_pend && !(i_pend && (consec_d >= CONSEC_MAX))) begin
        grant_d = 1'b1;
      end else if (i_pend) begin
        grant_i = 1'b1;
      end
    end
  end

  // Completion and read data go straight back to the owner in the same cycle.
  assign I_Ready    = (state == BUSY_I) && complete;
  assign D_Ready    = (state == BUSY_D) && complete;
  assign Bus_Error  = timeout_hit;
  assign Grant_D    = (state == BUSY_D);
  assign I_ReadData = M_ReadData;
  assign D_ReadData = M_ReadData;

  // Ownership FSM: IDLE -> BUSY_x on a grant, back to IDLE on completion or abort.
  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every flop in the
    // design samples pre-edge values, independent of block ordering.
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state <= BUSY_D;
          end else if (grant_i) begin
            state <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          if (complete) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Run length of D grants taken while I was waiting; saturates at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      consec_d <= '0;
    end else if (grant_d) begin
      if (!i_pend) begin
        consec_d <= '0;
      end else if (consec_d < CONSEC_MAX) begin
        consec_d <= consec_d + CW'(1);
      end
    end else if (grant_i) begin
      consec_d <= '0;
    end
  end

  // Hung-access watchdog: counts BUSY cycles that pass without M_Ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (grant_d || grant_i) begin
      tmo_cnt <= '0;
    end else if (TMO_EN && busy && !M_Ready && !timeout_hit) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Memory port registers: loaded on a grant, held through BUSY, enables
  // dropped on completion. Address and write data keep their last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      M_Address     <= '0;
      M_WriteData   <= '0;
      M_WriteEnable <= '0;
      M_ReadEnable  <= 1'b0;
    end else if (grant_d) begin
      M_Address     <= D_Address;
      M_WriteData   <= D_WriteData;
      M_WriteEnable <= D_WriteEnable;
      M_ReadEnable  <= D_ReadEnable;
    end else if (grant_i) begin
      M_Address     <= I_Address;
      M_WriteData   <= '0;
      M_WriteEnable <= '0;
      M_ReadEnable  <= 1'b1;
    end else if (complete) begin
      M_WriteEnable <= '0;
      M_ReadEnable  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a transaction-level
// reference model of the port owner.

module tb_mem_port_arbiter;

  localparam int MAX_DC = 4;
  localparam int TMO    = 8;

  logic        clock;
  logic        reset;
  logic [31:0] I_Address;
  logic        I_ReadEnable;
  logic [31:0] I_ReadData;
  logic        I_Ready;
  logic [31:0] D_Address;
  logic [31:0] D_WriteData;
  logic [3:0]  D_WriteEnable;
  logic        D_ReadEnable;
  logic [31:0] D_ReadData;
  logic        D_Ready;
  logic [31:0] M_Address;
  logic [31:0] M_WriteData;
  logic [3:0]  M_WriteEnable;
  logic        M_ReadEnable;
  logic [31:0] M_ReadData;
  logic        M_Ready;
  logic        Bus_Error;
  logic        Grant_D;

  mem_port_arbiter #(
    .MAX_DATA_CONSEC(MAX_DC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .I_Address    (I_Address),
    .I_ReadEnable (I_ReadEnable),
    .I_ReadData   (I_ReadData),
    .I_Ready      (I_Ready),
    .D_Address    (D_Address),
    .D_WriteData  (D_WriteData),
    .D_WriteEnable(D_WriteEnable),
    .D_ReadEnable (D_ReadEnable),
    .D_ReadData   (D_ReadData),
    .D_Ready      (D_Ready),
    .M_Address    (M_Address),
    .M_WriteData  (M_WriteData),
    .M_WriteEnable(M_WriteEnable),
    .M_ReadEnable (M_ReadEnable),
    .M_ReadData   (M_ReadData),
    .M_Ready      (M_Ready),
    .Bus_Error    (Bus_Error),
    .Grant_D      (Grant_D)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One in-flight transfer at most; who owns it, what it carries and how
  // long it has waited for the memory.
  typedef struct {
    bit          active;
    bit          to_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    int          waited;
  } xfer_t;

  xfer_t       cur;
  int          d_streak;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  bit          checking = 0;

  function automatic bit aborts_now();
    return cur.active && !M_Ready && (cur.waited == TMO - 1);
  endfunction

  function automatic bit finishes_now();
    return cur.active && (M_Ready || aborts_now());
  endfunction

  task automatic check_model();
    bit done;
    done = finishes_now();
    check("I_Ready",       32'(I_Ready),       32'(done && !cur.to_d));
    check("D_Ready",       32'(D_Ready),       32'(done && cur.to_d));
    check("Bus_Error",     32'(Bus_Error),     32'(aborts_now()));
    check("Grant_D",       32'(Grant_D),       32'(cur.active && cur.to_d));
    check("M_Address",     M_Address,          last_addr);
    check("M_WriteData",   M_WriteData,        last_wdata);
    check("M_WriteEnable", 32'(M_WriteEnable), cur.active ? 32'(cur.we) : 32'd0);
    check("M_ReadEnable",  32'(M_ReadEnable),  cur.active ? 32'(cur.re) : 32'd0);
    check("I_ReadData",    I_ReadData,         M_ReadData);
    check("D_ReadData",    D_ReadData,         M_ReadData);
  endtask

  task automatic model_step();
    bit ip, dp;
    if (reset) begin
      cur.active = 0;
      d_streak   = 0;
      last_addr  = '0;
      last_wdata = '0;
    end else if (cur.active) begin
      if (finishes_now()) cur.active = 0;
      else                cur.waited++;
    end else begin
      ip = I_ReadEnable;
      dp = D_ReadEnable || (D_WriteEnable != 4'd0);
      if (dp && !(ip && d_streak >= MAX_DC)) begin
        d_streak   = ip ? ((d_streak < MAX_DC) ? d_streak + 1 : MAX_DC) : 0;
        cur.active = 1;
        cur.to_d   = 1;
        cur.addr   = D_Address;
        cur.wdata  = D_WriteData;
        cur.we     = D_WriteEnable;
        cur.re     = D_ReadEnable;
        cur.waited = 0;
      end else if (ip) begin
        d_streak   = 0;
        cur.active = 1;
        cur.to_d   = 0;
        cur.addr   = I_Address;
        cur.wdata  = '0;
        cur.we     = '0;
        cur.re     = 1'b1;
        cur.waited = 0;
      end
      if (cur.active) begin
        last_addr  = cur.addr;
        last_wdata = cur.wdata;
      end
    end
  endtask

  // Inputs are changed just after a falling edge; outputs are compared 1 time
  // unit later, and the model advances with the values the rising edge sees.
  task automatic tick();
    #1;
    if (checking) check_model();
    model_step();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_idle();
    I_Address     = '0;
    I_ReadEnable  = 1'b0;
    D_Address     = '0;
    D_WriteData   = '0;
    D_WriteEnable = '0;
    D_ReadEnable  = 1'b0;
    M_ReadData    = '0;
    M_Ready       = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  d_before, d_after, n_seen;
    bit  i_seen, prev_gd, got, be;

    cur.active = 0;
    set_idle();
    reset = 1'b1;
    @(negedge clock);
    tick();
    tick();
    reset    = 1'b0;
    checking = 1;

    // Reset state
    settle();
    check("rst_m_re",    32'(M_ReadEnable), 32'd0);
    check("rst_m_we",    32'(M_WriteEnable), 32'd0);
    check("rst_grant_d", 32'(Grant_D), 32'd0);
    tick();

    // 1: reset held two cycles in the middle of a D access, late M_Ready ignored
    D_ReadEnable = 1'b1;
    D_Address    = 32'h0000_0040;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset        = 1'b0;
    D_ReadEnable = 1'b0;
    M_Ready      = 1'b1;
    M_ReadData   = 32'h5555_AAAA;
    settle();
    check("t1_m_re",    32'(M_ReadEnable), 32'd0);
    check("t1_m_addr",  M_Address, 32'd0);
    check("t1_grant_d", 32'(Grant_D), 32'd0);
    check("t1_d_ready", 32'(D_Ready), 32'd0);
    tick();
    set_idle();
    tick();

    // 2: lone I read, memory answers 3 cycles after the enable appears
    I_Address    = 32'h0000_1000;
    I_ReadEnable = 1'b1;
    settle();
    check("t2_m_re_idle", 32'(M_ReadEnable), 32'd0);
    tick();
    settle();
    check("t2_m_re",   32'(M_ReadEnable), 32'd1);
    check("t2_m_addr", M_Address, 32'h0000_1000);
    tick();
    tick();
    tick();
    M_Ready    = 1'b1;
    M_ReadData = 32'hDEAD_BEEF;
    settle();
    check("t2_i_ready", 32'(I_Ready), 32'd1);
    check("t2_i_rdata", I_ReadData, 32'hDEAD_BEEF);
    check("t2_d_ready", 32'(D_Ready), 32'd0);
    tick();
    I_ReadEnable = 1'b0;
    M_Ready      = 1'b0;
    settle();
    check("t2_m_re_after", 32'(M_ReadEnable), 32'd0);
    tick();

    // 3: both pending in the same IDLE cycle, D write wins, then I
    D_Address     = 32'h0000_0200;
    D_WriteData   = 32'h1234_5678;
    D_WriteEnable = 4'b0011;
    I_Address     = 32'h0000_1004;
    I_ReadEnable  = 1'b1;
    tick();
    settle();
    check("t3_grant_d", 32'(Grant_D), 32'd1);
    check("t3_m_we",    32'(M_WriteEnable), 32'h3);
    check("t3_m_wdata", M_WriteData, 32'h1234_5678);
    M_Ready = 1'b1;
    settle();
    check("t3_d_ready", 32'(D_Ready), 32'd1);
    check("t3_i_ready", 32'(I_Ready), 32'd0);
    tick();
    D_WriteEnable = 4'b0000;
    M_Ready       = 1'b0;
    settle();
    check("t3_idle_gap", 32'(M_WriteEnable | {3'b0, M_ReadEnable}), 32'd0);
    tick();
    settle();
    check("t3_i_granted", 32'(M_ReadEnable), 32'd1);
    check("t3_i_addr",    M_Address, 32'h0000_1004);
    M_Ready = 1'b1;
    tick();
    set_idle();
    tick();

    // 4: starvation bound, D continuous, I held until served
    D_ReadEnable = 1'b1;
    D_Address    = 32'h0000_0300;
    I_ReadEnable = 1'b1;
    I_Address    = 32'h0000_2000;
    M_Ready      = 1'b1;
    d_before = 0;
    d_after  = 0;
    i_seen   = 0;
    prev_gd  = 0;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (Grant_D && !prev_gd) begin
        if (i_seen) d_after++;
        else        d_before++;
      end
      prev_gd = Grant_D;
      if (I_Ready) i_seen = 1;
      tick();
      if (i_seen) I_ReadEnable = 1'b0;
    end
    check("t4_d_before_i", 32'(d_before), 32'd4);
    check("t4_i_served",   32'(i_seen), 32'd1);
    check("t4_d_resumes",  32'(d_after > 0), 32'd1);
    set_idle();
    tick();

    // 5: timeout on a D read; second pass answers on the last cycle instead
    for (int variant = 0; variant < 2; variant++) begin
      D_ReadEnable = 1'b1;
      D_Address    = 32'h0000_0400;
      tick();
      got    = 0;
      be     = 0;
      n_seen = 0;
      for (int k = 1; k <= 20 && !got; k++) begin
        M_Ready = (variant == 1) && (k == 8);
        settle();
        if (D_Ready) begin
          got    = 1;
          n_seen = k;
          be     = Bus_Error;
        end
        tick();
      end
      D_ReadEnable = 1'b0;
      M_Ready      = 1'b0;
      check("t5_ready_cycle", 32'(n_seen), 32'd8);
      check("t5_bus_error",   32'(be), 32'(variant == 0));
      tick();
    end

    // 6: stray M_Ready while idle, requester inputs wandering during BUSY
    M_Ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      M_ReadData = $urandom;
      tick();
    end
    M_Ready       = 1'b0;
    D_Address     = 32'h0000_0500;
    D_WriteData   = 32'hA5A5_0000;
    D_WriteEnable = 4'b1000;
    tick();
    for (int k = 0; k < 4; k++) begin
      D_Address     = $urandom;
      D_WriteData   = $urandom;
      D_WriteEnable = 4'($urandom);
      D_ReadEnable  = 1'($urandom);
      I_ReadEnable  = 1'($urandom);
      I_Address     = $urandom;
      settle();
      check("t6_m_addr",  M_Address, 32'h0000_0500);
      check("t6_m_wdata", M_WriteData, 32'hA5A5_0000);
      check("t6_m_we",    32'(M_WriteEnable), 32'h8);
      tick();
    end
    M_Ready = 1'b1;
    tick();
    set_idle();
    tick();

    // Randomized traffic, including silent-memory stretches and random resets
    for (int blk = 0; blk < 15; blk++) begin
      for (int k = 0; k < 200; k++) begin
        reset         = ($urandom_range(99) == 0);
        I_ReadEnable  = ($urandom_range(2) != 0);
        I_Address     = $urandom;
        D_Address     = $urandom;
        D_WriteData   = $urandom;
        D_ReadEnable  = ($urandom_range(2) == 0);
        D_WriteEnable = ($urandom_range(2) == 0) ? 4'($urandom) : 4'd0;
        M_ReadData    = $urandom;
        M_Ready       = (blk % 4 == 3) ? 1'b0 : ($urandom_range(2) == 0);
        tick();
      end
    end
    reset = 1'b0;
    set_idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
